// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port BRAM: IDLE -> ACCESS -> CAPTURE per access.
// Build option DMEM_ARB_FIXED_PRIO_EN: r0 always wins contention (default: round-robin).
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_gnt,
  output logic              r1_gnt,
  output logic              r0_done,
  output logic              r1_done,
  output logic [DATA_W-1:0] r0_rdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                id_q, id_d;
  logic                we_q, we_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                win_c;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // r1 wins only when r0 is not asking
  always_comb win_c = ~r0_req;
`else
  logic last_q, last_d;

  // On contention the requester not served last wins
  always_comb win_c = (r0_req && r1_req) ? ~last_q : r1_req;
`endif

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    we_d        = we_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          // Everything about the access is captured here so later input changes are ignored
          id_d        = win_c;
          we_d        = win_c ? r1_we : r0_we;
          mem_addr_d  = win_c ? r1_addr : r0_addr;
          mem_wdata_d = win_c ? r1_wdata : r0_wdata;
          gnt0_d      = ~win_c;
          gnt1_d      = win_c;
          mem_en_d    = 1'b1;
          mem_we_d    = win_c ? r1_we : r0_we;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          last_d      = win_c;
`endif
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (!we_q) begin
          if (id_q) rdata1_d = mem_rdata;
          else      rdata0_d = mem_rdata;
        end
        done0_d = ~id_q;
        done1_d = id_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= 1'b0;
      we_q        <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      we_q        <= we_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  assign r0_gnt    = gnt0_q;
  assign r1_gnt    = gnt1_q;
  assign r0_done   = done0_q;
  assign r1_done   = done1_q;
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: BRAM model, transaction-level reference model, directed and random traffic.
module tb_dmem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          r0_req = 1'b0, r1_req = 1'b0, r0_we = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_gnt, r1_gnt, r0_done, r1_done, mem_en, mem_we;
  logic [DW-1:0] r0_rdata, r1_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] bram [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_done(r0_done), .r1_done(r1_done),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < int'(DEPTH); i++) bram[i] = '0;

  // Synchronous BRAM, read data valid one cycle after the enabled edge
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
    end
  end

  function automatic void chk1(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chkd(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void tmo(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout required event at %0t", nm, $time);
  endfunction

  // Reference model: an accepted access at edge t gives gnt/mem_en after t, memory effect at t+1,
  // done (and read-data update) after t+2, and the arbiter is free again from edge t+3.
  int            cyc = 0;
  int            t_acc = -100;
  int            last_m = 1;
  logic          p_id = 1'b0, p_we = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0, p_rd = '0;
  logic [DW-1:0] golden [DEPTH];
  logic          e_gnt0 = 1'b0, e_gnt1 = 1'b0, e_done0 = 1'b0, e_done1 = 1'b0;
  logic          e_mem_en = 1'b0, e_mem_we = 1'b0;
  logic [AW-1:0] e_mem_addr = '0;
  logic [DW-1:0] e_mem_wdata = '0, e_rdata0 = '0, e_rdata1 = '0;

  initial for (int i = 0; i < int'(DEPTH); i++) golden[i] = '0;

  always @(posedge clk or posedge rst) begin
    int w;
    if (rst) begin
      t_acc = -100; last_m = 1;
      e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0; e_mem_en = 0; e_mem_we = 0;
      e_mem_addr = '0; e_mem_wdata = '0; e_rdata0 = '0; e_rdata1 = '0;
    end else begin
      cyc++;
      if (cyc == t_acc + 1) begin
        if (p_we) golden[p_addr] = p_wdata;
        else      p_rd = golden[p_addr];
      end
      if (cyc == t_acc + 2 && !p_we) begin
        if (p_id) e_rdata1 = p_rd;
        else      e_rdata0 = p_rd;
      end
      if (cyc >= t_acc + 3 && (r0_req || r1_req)) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        w = r0_req ? 0 : 1;
`else
        if (r0_req && r1_req) w = 1 - last_m;
        else                  w = r1_req ? 1 : 0;
        last_m = w;
`endif
        t_acc   = cyc;
        p_id    = (w == 1);
        p_we    = p_id ? r1_we : r0_we;
        p_addr  = p_id ? r1_addr : r0_addr;
        p_wdata = p_id ? r1_wdata : r0_wdata;
        e_mem_addr  = p_addr;
        e_mem_wdata = p_wdata;
      end
      e_mem_en = (cyc == t_acc);
      e_mem_we = e_mem_en && p_we;
      e_gnt0   = e_mem_en && !p_id;
      e_gnt1   = e_mem_en && p_id;
      e_done0  = (cyc == t_acc + 2) && !p_id;
      e_done1  = (cyc == t_acc + 2) && p_id;
    end
  end

  int   gq[$];
  logic saw_done1 = 1'b0;

  // Per-cycle comparison against the model, plus invariants
  always @(negedge clk) begin
    chk1("gnt0", r0_gnt, e_gnt0);
    chk1("gnt1", r1_gnt, e_gnt1);
    chk1("done0", r0_done, e_done0);
    chk1("done1", r1_done, e_done1);
    chk1("mem_en", mem_en, e_mem_en);
    chk1("mem_we", mem_we, e_mem_we);
    chkd("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
    if (mem_en) chkd("mem_wdata", mem_wdata, e_mem_wdata);
    chkd("rdata0", r0_rdata, e_rdata0);
    chkd("rdata1", r1_rdata, e_rdata1);
    chk1("gnt_both", r0_gnt && r1_gnt, 1'b0);
    chk1("done_both", r0_done && r1_done, 1'b0);
    chk1("we_without_en", mem_we && !mem_en, 1'b0);
    if (r0_gnt) gq.push_back(0);
    if (r1_gnt) gq.push_back(1);
    if (r1_done) saw_done1 = 1'b1;
  end

  task automatic drive(input int r, input logic req, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (r == 0) begin r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d; end
    else        begin r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d; end
  endtask

  // One access: hold req until gnt, then scramble the inputs and wait for done
  task automatic access(input int r, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int g, output int dn);
    g = -1; dn = -1;
    drive(r, 1'b1, we, a, d);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if ((r == 0) ? r0_gnt : r1_gnt) begin g = cyc; break; end
    end
    drive(r, 1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
    if (g < 0) begin tmo("gnt_wait"); return; end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if ((r == 0) ? r0_done : r1_done) begin dn = cyc; break; end
    end
    if (dn < 0) tmo("done_wait");
  endtask

  task automatic do_reset();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic rand_traffic(input int r, input int n);
    int g, dn;
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      a = ($urandom_range(0, 3) == 0) ? 10'h3FF : AW'($urandom_range(0, 7));
      access(r, 1'($urandom_range(0, 1)), a, DW'($urandom), g, dn);
    end
  endtask

  initial begin
    int g, dn, g0, d0, g1, d1;
    bit seen;
    #1 rst = 1'b1;
    #1;
    chk1("rst_gnt0", r0_gnt, 1'b0);
    chk1("rst_gnt1", r1_gnt, 1'b0);
    chk1("rst_done", r0_done | r1_done, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chkd("rst_mem_addr", 32'(mem_addr), 32'h0);
    chkd("rst_mem_wdata", mem_wdata, 32'h0);
    chkd("rst_rdata0", r0_rdata, 32'h0);
    chkd("rst_rdata1", r1_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Write then read back through r0
    access(0, 1'b1, 10'h005, 32'hDEADBEEF, g, dn);
    access(0, 1'b0, 10'h005, 32'h0, g, dn);
    chkd("wr_rd_r0_rdata", r0_rdata, 32'hDEADBEEF);
    chkd("gnt_to_done", 32'(dn - g), 32'd2);

    // Simultaneous requests after reset: r0 first, r1 right after r0's done
    do_reset();
    fork
      access(0, 1'b0, 10'h010, 32'h0, g0, d0);
      access(1, 1'b1, 10'h3FF, 32'h12345678, g1, d1);
    join
    chk1("contend_r0_first", g0 < g1, 1'b1);
    chkd("contend_r1_gnt_cycle", 32'(g1), 32'(d0 + 1));
    chkd("contend_r0_rdata", r0_rdata, 32'h0);
    access(1, 1'b0, 10'h3FF, 32'h0, g, dn);
    chkd("top_addr_read", r1_rdata, 32'h12345678);

    // Write must not disturb the read holding register
    access(1, 1'b1, 10'h3FF, 32'h0, g, dn);
    chkd("rdata_hold_on_write", r1_rdata, 32'h12345678);

    // Reset during ACCESS abandons the access
    drive(1, 1'b1, 1'b1, 10'h020, 32'hAAAA5555);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (r1_gnt) begin seen = 1; break; end
    end
    if (!seen) tmo("abort_gnt_wait");
    saw_done1 = 1'b0;
    rst = 1'b1;
    #1;
    chk1("abort_mem_en_drop", mem_en, 1'b0);
    chk1("abort_gnt_drop", r1_gnt, 1'b0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk1("abort_no_done", saw_done1, 1'b0);
    access(1, 1'b1, 10'h020, 32'hAAAA5555, g, dn);
    access(1, 1'b0, 10'h020, 32'h0, g, dn);
    chkd("abort_reissue_read", r1_rdata, 32'hAAAA5555);

    // Both requests held for six grants
    do_reset();
    gq.delete();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'h001;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 10'h002;
    for (int i = 0; i < 40 && gq.size() < 6; i++) begin
      @(negedge clk); #1;
    end
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    if (gq.size() < 6) tmo("held_grants");
    else begin
      for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        chkd("held_grant_order", 32'(gq[i]), 32'd0);
`else
        chkd("held_grant_order", 32'(gq[i]), 32'(i % 2));
`endif
      end
    end

    // Random concurrent traffic, checked every cycle by the model
    fork
      rand_traffic(0, 40);
      rand_traffic(1, 40);
    join
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: ADDR_W, 10, word address width; DATA_W, 32, data width.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 r0_req, r1_req  input  1  access request, level, held until the matching gnt is seen.
REQ-005 r0_we, r1_we  input  1  1 = write, 0 = read; sampled with req.
REQ-006 r0_addr, r1_addr  input  ADDR_W  word address.
REQ-007 r0_wdata, r1_wdata  input  DATA_W  write data.
REQ-008 r0_gnt, r1_gnt  output  1  request accepted; one-cycle pulse.
REQ-009 r0_done, r1_done  output  1  access complete; one-cycle pulse.
REQ-010 r0_rdata, r1_rdata  output  DATA_W  per-requester read-data holding register.
REQ-011 mem_en, mem_we  output  1  BRAM enable and write enable.
REQ-012 mem_addr  output  ADDR_W  BRAM address.
REQ-013 mem_wdata  output  DATA_W  BRAM write data.
REQ-014 mem_rdata  input  DATA_W  BRAM read data, valid one cycle after the enabled edge.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, CAPTURE.
REQ-016 IDLE: if any req is high at the edge, latch the winner's id, we, addr and wdata, then go to ACCESS; otherwise stay in IDLE.
REQ-017 ACCESS, one cycle: gnt of the winner = 1; mem_en = 1; mem_we = latched we; mem_addr and mem_wdata = latched values; next state CAPTURE.
REQ-018 CAPTURE, one cycle: mem_en = 0; on a read, winner's rdata <= mem_rdata at the closing edge; next state IDLE.
REQ-019 The cycle after CAPTURE SHALL have the winner's done = 1; that cycle is IDLE and may accept a new request.
REQ-020 Latency SHALL be: req sampled at edge E0; gnt in cycle E0..E1; done in cycle E2..E3. Maximum throughput is one access per 3 cycles.
REQ-021 Arbitration SHALL be round-robin.
- A single requester always wins.
- When both request, the requester not served last wins.
- The last-served pointer updates on every grant.
REQ-022 mem_we SHALL be 0 whenever mem_en = 0; mem_en SHALL be high only in ACCESS.
REQ-023 rN_rdata SHALL change only on completion of a read by requester N, and SHALL hold its value across writes and across the other requester's accesses.
REQ-024 gnt and done SHALL never be asserted for both requesters in the same cycle.
REQ-025 A req still high in the done cycle SHALL be treated as a new request.
REQ-026 The full address range 0x000..0x3FF SHALL be passed through unmodified: no wrap and no bounds check.
REQ-027 Inputs changing outside IDLE SHALL NOT affect the access in flight, because they are latched at acceptance.

Reset
REQ-028 rst SHALL force the following immediately, without waiting for clk:
- state = IDLE;
- all gnt, done, mem_en and mem_we = 0;
- mem_addr, mem_wdata and all rdata = 0;
- last-served pointer = 1, so r0 wins the first contention.
REQ-029 Reset asserted during ACCESS SHALL drop mem_en at once. The access is abandoned with no done pulse, and the requester SHALL reissue it.

Configuration
REQ-030 Macro DMEM_ARB_FIXED_PRIO_EN:
- When defined, r0 SHALL always win contention and the pointer logic is absent.
- When undefined, round-robin per REQ-021 applies.
- Latency and handshakes are identical in both builds.

Verification
REQ-031 Reset, then r0 write 0x005 = 0xDEADBEEF, then r0 read 0x005 -> r0_rdata = 0xDEADBEEF with r0_done exactly 2 cycles after r0_gnt.
REQ-032 After reset, r0 read 0x010 and r1 write 0x3FF = 0x12345678 raised in the same cycle -> r0_gnt first; r1_gnt in the first IDLE cycle after r0_done; then r1 read 0x3FF returns 0x12345678.
REQ-033 Both req held continuously for 6 grants -> grant order 0,1,0,1,0,1; never gnt or done on both in the same cycle.
REQ-034 rst pulsed in the ACCESS cycle of an r1 write 0x020 = 0xAAAA5555 -> mem_en = 0 within the same cycle, no r1_done, state IDLE; after release, r1 reissues and a read of 0x020 returns 0xAAAA5555.
REQ-035 r1 read 0x3FF (value 0x12345678), then r1 write 0x3FF = 0x0 -> r1_rdata stays 0x12345678 after the write's done.
REQ-036 With DMEM_ARB_FIXED_PRIO_EN defined, both req held continuously -> r0_gnt on every grant and r1 never granted.
